// File: rtl/ioctl_rom_loader.sv
// ioctl download consumer: packs bytes into 16-bit SDRAM words,
// stalls the HPS during writes, captures DIP bytes, flags ROM ready.
module ioctl_rom_loader #(
  parameter logic [15:0] ROM_INDEX = 16'd0,
  parameter logic [15:0] DIP_INDEX = 16'd254,
  parameter logic [26:0] ROM_BYTES = 27'h0100000,
  parameter int          SDRAM_AW  = 22
) (
  input  logic                i_EMU_MCLK,
  input  logic                i_EMU_INITRST,
  input  logic [15:0]         ioctl_index,
  input  logic                ioctl_download,
  input  logic [26:0]         ioctl_addr,
  input  logic [7:0]          ioctl_data,
  input  logic                ioctl_wr,
  output logic                ioctl_wait,
  output logic                o_SDRAM_WR_REQ,
  output logic [SDRAM_AW-1:0] o_SDRAM_ADDR,
  output logic [15:0]         o_SDRAM_DATA,
  input  logic                i_SDRAM_WR_ACK,
  output logic [23:0]         o_DIPSW,
  output logic                o_ROM_READY,
  output logic                o_ERR
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    REQ,
    FLUSH
  } state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic                even_q, even_d;
  logic [SDRAM_AW-1:0] addr_q, addr_d;
  logic [15:0]         data_q, data_d;
  logic [23:0]         dip_q, dip_d;
  logic                ready_q, ready_d;
  logic                err_q, err_d;

  logic rom_sel, rom_wr, dip_wr;

  // Byte qualification; any strobe during a stall is dropped
  always_comb begin
    rom_sel = (ioctl_index == ROM_INDEX);
    rom_wr  = ioctl_wr && !req_q && rom_sel
              && (ioctl_addr < ROM_BYTES);
    dip_wr  = ioctl_wr && !req_q
              && (ioctl_index == DIP_INDEX)
              && (ioctl_addr < 27'd3);
  end

  // Next-state, word packing, DIP capture and status flags
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    even_d  = even_q;
    addr_d  = addr_q;
    data_d  = data_q;
    dip_d   = dip_q;
    ready_d = ready_q;
    err_d   = err_q;

    if (ioctl_wr && req_q) err_d = 1'b1;

    if (dip_wr) begin
      case (ioctl_addr[1:0])
        2'd0:    dip_d[7:0]   = ioctl_data;
        2'd1:    dip_d[15:8]  = ioctl_data;
        2'd2:    dip_d[23:16] = ioctl_data;
        default: ;
      endcase
    end

    unique case (state_q)
      IDLE: begin
        if (ioctl_download && rom_sel) begin
          state_d = COLLECT;
          ready_d = 1'b0;
          even_d  = 1'b0;
        end
      end
      COLLECT: begin
        if (!ioctl_download) begin
          if (even_q) begin
            state_d = FLUSH;
            req_d   = 1'b1;
            data_d  = {8'h00, data_q[7:0]};
          end else begin
            state_d = IDLE;
            ready_d = 1'b1;
          end
        end else if (rom_wr) begin
          addr_d = ioctl_addr[SDRAM_AW:1];
          if (!ioctl_addr[0]) begin
            data_d[7:0] = ioctl_data;
            even_d      = 1'b1;
          end else begin
            data_d  = {ioctl_data,
                       even_q ? data_q[7:0] : 8'h00};
            req_d   = 1'b1;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (i_SDRAM_WR_ACK) begin
          req_d   = 1'b0;
          even_d  = 1'b0;
          state_d = COLLECT;
        end
      end
      FLUSH: begin
        if (i_SDRAM_WR_ACK) begin
          req_d   = 1'b0;
          even_d  = 1'b0;
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any request
  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST) begin
    if (i_EMU_INITRST) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      even_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= 16'h0000;
      dip_q   <= 24'h000000;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      even_q  <= even_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      dip_q   <= dip_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign ioctl_wait     = req_q;
  assign o_SDRAM_WR_REQ = req_q;
  assign o_SDRAM_ADDR   = addr_q;
  assign o_SDRAM_DATA   = data_q;
  assign o_DIPSW        = dip_q;
  assign o_ROM_READY    = ready_q;
  assign o_ERR          = err_q;

endmodule
